// File: rtl/register_file_scoreboard.sv
// register_file_scoreboard
//   Parametrised register file with two combinational read ports, one write
//   port and a per-register busy scoreboard. Decode reserves destination
//   registers (reserveEnable/reserveAddress) and checks source busy bits
//   (aBusy/bBusy). Writeback writes data and clears the busy bit.
//
//   Parameters: WIDTH data width, DEPTH register count (power of two, >= 2),
//               ZERO_REG hardwires register 0 to zero, BYPASS forwards
//               same-cycle write data to the read ports.
//   Ports:
//     clk, reset                        clock, async active-high reset
//     in, writeAddress, writeEnable     write port
//     aAddress/aOut/aBusy               read port A (data + busy)
//     bAddress/bOut/bBusy               read port B (data + busy)
//     reserveEnable, reserveAddress     reserve request
//     reserveAccept                     reserve taken this cycle
//     busyCount                         number of busy registers
module register_file_scoreboard #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 4,
  parameter int ZERO_REG = 0,
  parameter int BYPASS   = 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [WIDTH-1:0]             in,
  input  logic [$clog2(DEPTH)-1:0]     writeAddress,
  input  logic                         writeEnable,
  input  logic [$clog2(DEPTH)-1:0]     aAddress,
  input  logic [$clog2(DEPTH)-1:0]     bAddress,
  output logic [WIDTH-1:0]             aOut,
  output logic [WIDTH-1:0]             bOut,
  output logic                         aBusy,
  output logic                         bBusy,
  input  logic                         reserveEnable,
  input  logic [$clog2(DEPTH)-1:0]     reserveAddress,
  output logic                         reserveAccept,
  output logic [$clog2(DEPTH+1)-1:0]   busyCount
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam bit ZR     = (ZERO_REG != 0);
  localparam bit BP     = (BYPASS != 0);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;
  logic [DEPTH-1:0]            busy_q, busy_d;
  logic [CNT_W-1:0]            count_q, count_d;

  logic write_ok;
  logic reserve_set;

  function automatic logic [WIDTH-1:0] read_port(
    input logic [ADDR_W-1:0]           addr,
    input logic [DEPTH-1:0][WIDTH-1:0] mem,
    input logic                        fwd_en,
    input logic [ADDR_W-1:0]           waddr,
    input logic [WIDTH-1:0]            wdata
  );
    logic [WIDTH-1:0] r;
    r = mem[addr];
    if (ZR && (addr == '0)) begin
      r = '0;
    end else if (BP && fwd_en && (waddr == addr)) begin
      r = wdata;
    end
    return r;
  endfunction

  // Forwarding is suppressed while reset is held; stored values are already
  // cleared asynchronously, so outputs read zero during reset.
  always_comb begin
    aOut = read_port(aAddress, mem_q, writeEnable && !reset, writeAddress, in);
    bOut = read_port(bAddress, mem_q, writeEnable && !reset, writeAddress, in);
  end

  assign aBusy     = busy_q[aAddress];
  assign bBusy     = busy_q[bAddress];
  assign busyCount = count_q;

  // A busy register can still be reserved in the cycle its pending write
  // lands: the write clears the old producer and the new reserve wins.
  assign reserveAccept = reserveEnable && !reset &&
                         (!busy_q[reserveAddress] ||
                          (writeEnable && (writeAddress == reserveAddress)));

  assign write_ok    = writeEnable && !(ZR && (writeAddress == '0));
  assign reserve_set = reserveAccept && !(ZR && (reserveAddress == '0));

  always_comb begin
    mem_d   = mem_q;
    busy_d  = busy_q;
    count_d = '0;
    if (write_ok) begin
      mem_d[writeAddress]  = in;
      busy_d[writeAddress] = 1'b0;
    end
    // Applied after the write so a same-address reserve ends busy.
    if (reserve_set) begin
      busy_d[reserveAddress] = 1'b1;
    end
    for (int unsigned i = 0; i < DEPTH; i++) begin
      count_d = count_d + CNT_W'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q   <= '0;
      busy_q  <= '0;
      count_q <= '0;
    end else begin
      mem_q   <= mem_d;
      busy_q  <= busy_d;
      count_q <= count_d;
    end
  end

endmodule

// File: tb/tb_register_file_scoreboard.sv
module tb_register_file_scoreboard;

  logic       clk;
  logic       reset;
  logic [7:0] in;
  logic [1:0] writeAddress;
  logic       writeEnable;
  logic [1:0] aAddress, bAddress;
  logic       reserveEnable;
  logic [1:0] reserveAddress;

  logic [7:0] aOut, bOut, aOut_nb, bOut_nb, aOut_z, bOut_z;
  logic       aBusy, bBusy, aBusy_nb, bBusy_nb, aBusy_z, bBusy_z;
  logic       acc, acc_nb, acc_z;
  logic [2:0] cnt, cnt_nb, cnt_z;

  int compared   = 0;
  int mismatched = 0;

  register_file_scoreboard #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(1)) dut (
    .clk(clk), .reset(reset), .in(in), .writeAddress(writeAddress),
    .writeEnable(writeEnable), .aAddress(aAddress), .bAddress(bAddress),
    .aOut(aOut), .bOut(bOut), .aBusy(aBusy), .bBusy(bBusy),
    .reserveEnable(reserveEnable), .reserveAddress(reserveAddress),
    .reserveAccept(acc), .busyCount(cnt));

  register_file_scoreboard #(.WIDTH(8), .DEPTH(4), .ZERO_REG(0), .BYPASS(0)) dut_nb (
    .clk(clk), .reset(reset), .in(in), .writeAddress(writeAddress),
    .writeEnable(writeEnable), .aAddress(aAddress), .bAddress(bAddress),
    .aOut(aOut_nb), .bOut(bOut_nb), .aBusy(aBusy_nb), .bBusy(bBusy_nb),
    .reserveEnable(reserveEnable), .reserveAddress(reserveAddress),
    .reserveAccept(acc_nb), .busyCount(cnt_nb));

  register_file_scoreboard #(.WIDTH(8), .DEPTH(4), .ZERO_REG(1), .BYPASS(1)) dut_z (
    .clk(clk), .reset(reset), .in(in), .writeAddress(writeAddress),
    .writeEnable(writeEnable), .aAddress(aAddress), .bAddress(bAddress),
    .aOut(aOut_z), .bOut(bOut_z), .aBusy(aBusy_z), .bBusy(bBusy_z),
    .reserveEnable(reserveEnable), .reserveAddress(reserveAddress),
    .reserveAccept(acc_z), .busyCount(cnt_z));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       we;
    logic [1:0] wa;
    logic [7:0] din;
    logic       re;
    logic [1:0] ra;
    logic [1:0] aa;
    logic [1:0] ba;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       eab;
    logic       ebb;
    logic       eacc;
    logic [2:0] ecnt;
    logic [7:0] ea_nb;
    logic [7:0] ea_z;
    logic [2:0] ecnt_z;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    writeEnable    = 1'b0;
    writeAddress   = '0;
    in             = '0;
    reserveEnable  = 1'b0;
    reserveAddress = '0;
  endtask

  initial begin
    //           we  wa din    re  ra  aa  ba   ea     eb     aB  bB  acc cnt  a_nb   a_z    cnt_z
    vecs[0]  = '{1, 2, 8'hA5, 0, 0, 2, 3, 8'hA5, 8'h00, 0, 0, 0, 0, 8'h00, 8'hA5, 0};
    vecs[1]  = '{0, 0, 8'h00, 0, 0, 2, 3, 8'hA5, 8'h00, 0, 0, 0, 0, 8'hA5, 8'hA5, 0};
    vecs[2]  = '{1, 1, 8'h3C, 0, 0, 1, 2, 8'h3C, 8'hA5, 0, 0, 0, 0, 8'h00, 8'h3C, 0};
    vecs[3]  = '{0, 0, 8'h00, 1, 3, 3, 1, 8'h00, 8'h3C, 0, 0, 1, 1, 8'h00, 8'h00, 1};
    vecs[4]  = '{0, 0, 8'h00, 1, 3, 3, 0, 8'h00, 8'h00, 1, 0, 0, 1, 8'h00, 8'h00, 1};
    vecs[5]  = '{1, 3, 8'h77, 0, 0, 3, 3, 8'h77, 8'h77, 1, 1, 0, 0, 8'h00, 8'h77, 0};
    vecs[6]  = '{0, 0, 8'h00, 0, 0, 3, 2, 8'h77, 8'hA5, 0, 0, 0, 0, 8'h77, 8'h77, 0};
    vecs[7]  = '{0, 0, 8'h00, 1, 2, 2, 3, 8'hA5, 8'h77, 0, 0, 1, 1, 8'hA5, 8'hA5, 1};
    vecs[8]  = '{1, 2, 8'h11, 1, 2, 2, 2, 8'h11, 8'h11, 1, 1, 1, 1, 8'hA5, 8'h11, 1};
    vecs[9]  = '{0, 0, 8'h00, 0, 0, 2, 1, 8'h11, 8'h3C, 1, 0, 0, 1, 8'h11, 8'h11, 1};
    vecs[10] = '{1, 0, 8'h5A, 0, 0, 0, 2, 8'h5A, 8'h11, 0, 1, 0, 1, 8'h00, 8'h00, 1};
    vecs[11] = '{0, 0, 8'h00, 1, 0, 0, 1, 8'h5A, 8'h3C, 0, 0, 1, 2, 8'h5A, 8'h00, 1};
    vecs[12] = '{0, 0, 8'h00, 1, 1, 1, 0, 8'h3C, 8'h5A, 0, 1, 1, 3, 8'h3C, 8'h3C, 2};
    vecs[13] = '{0, 0, 8'h00, 1, 3, 3, 2, 8'h77, 8'h11, 0, 1, 1, 4, 8'h77, 8'h77, 3};
    vecs[14] = '{0, 0, 8'h00, 1, 1, 1, 3, 8'h3C, 8'h77, 1, 1, 0, 4, 8'h3C, 8'h3C, 3};

    reset = 1'b1;
    idle();
    aAddress = '0;
    bAddress = '0;

    // Reset held: write/reserve requests must be ignored and not forwarded.
    @(posedge clk); #1;
    writeEnable = 1'b1; writeAddress = 2'd1; in = 8'hFF;
    reserveEnable = 1'b1; reserveAddress = 2'd1;
    aAddress = 2'd1; bAddress = 2'd1;
    #1;
    chk("rst aOut", aOut, 8'h00);
    chk("rst bOut", bOut, 8'h00);
    chk("rst aBusy", aBusy, 1'b0);
    chk("rst accept", acc, 1'b0);
    @(posedge clk); #1;
    idle();
    chk("rst busyCount", cnt, 3'd0);
    for (int a = 0; a < 4; a++) begin
      aAddress = 2'(a);
      bAddress = 2'(3 - a);
      #1;
      chk($sformatf("rst read a%0d", a), aOut, 8'h00);
      chk($sformatf("rst read b%0d", 3 - a), bOut, 8'h00);
    end
    reset = 1'b0;

    foreach (vecs[i]) begin
      writeEnable    = vecs[i].we;
      writeAddress   = vecs[i].wa;
      in             = vecs[i].din;
      reserveEnable  = vecs[i].re;
      reserveAddress = vecs[i].ra;
      aAddress       = vecs[i].aa;
      bAddress       = vecs[i].ba;
      #1;
      chk($sformatf("v%0d aOut", i), aOut, vecs[i].ea);
      chk($sformatf("v%0d bOut", i), bOut, vecs[i].eb);
      chk($sformatf("v%0d aBusy", i), aBusy, vecs[i].eab);
      chk($sformatf("v%0d bBusy", i), bBusy, vecs[i].ebb);
      chk($sformatf("v%0d reserveAccept", i), acc, vecs[i].eacc);
      chk($sformatf("v%0d nobypass aOut", i), aOut_nb, vecs[i].ea_nb);
      chk($sformatf("v%0d zero aOut", i), aOut_z, vecs[i].ea_z);
      chk($sformatf("v%0d zero reserveAccept", i), acc_z, vecs[i].eacc);
      @(posedge clk); #1;
      chk($sformatf("v%0d busyCount", i), cnt, vecs[i].ecnt);
      chk($sformatf("v%0d zero busyCount", i), cnt_z, vecs[i].ecnt_z);
    end

    // All four registers busy; assert reset mid-cycle and expect the
    // scoreboard and data to clear before the next clock edge.
    writeEnable = 1'b1; writeAddress = 2'd2; in = 8'hEE;
    reserveEnable = 1'b1; reserveAddress = 2'd1;
    aAddress = 2'd2; bAddress = 2'd3;
    #2;
    reset = 1'b1;
    #1;
    chk("async busyCount", cnt, 3'd0);
    chk("async aOut", aOut, 8'h00);
    chk("async bOut", bOut, 8'h00);
    chk("async aBusy", aBusy, 1'b0);
    chk("async bBusy", bBusy, 1'b0);
    chk("async accept", acc, 1'b0);
    chk("async zero busyCount", cnt_z, 3'd0);
    chk("async nobypass aOut", aOut_nb, 8'h00);
    for (int a = 0; a < 4; a++) begin
      aAddress = 2'(a);
      #1;
      chk($sformatf("async read a%0d", a), aOut, 8'h00);
    end
    @(posedge clk); #1;
    idle();
    reset = 1'b0;
    aAddress = 2'd2;
    @(posedge clk); #1;
    chk("post-reset busyCount", cnt, 3'd0);
    chk("post-reset r2", aOut, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
